// File: rtl/spi_pkg.sv
// Shared definitions for the SPI shift register: FSM state encoding, bit-order
// codes and the default frame width.
package spi_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_e;

  localparam logic OrdMsb = 1'b0;
  localparam logic OrdLsb = 1'b1;

  localparam int unsigned DefaultWidth = 8;

endpackage

// File: rtl/spi_shr.sv
// Parametrised SPI shift register with per-frame bit order, split sample/shift
// strobes, bit counter, busy/done status and a received-word holding register.
module spi_shr
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH    = DefaultWidth,
  parameter logic        IDLE_OUT = 1'b1,
  localparam int unsigned CNT_W   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] ld_data_i,
  input  logic             lsb_first_i,
  input  logic             smp_i,
  input  logic             sh_i,
  input  logic             din_i,
  output logic             dout_o,
  output logic [WIDTH-1:0] dstr_o,
  output logic [WIDTH-1:0] rx_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] bit_cnt_o
);

  localparam logic [CNT_W-1:0] LastBit = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dstr_q, dstr_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sample_q, sample_d;
  logic             ord_q, ord_d;

  logic             in_bit;
  logic [WIDTH-1:0] shifted;

  // With smp and sh together the live din is used, so tying smp to sh gives
  // the legacy single-strobe behaviour.
  always_comb begin
    in_bit  = smp_i ? din_i : sample_q;
    shifted = (ord_q == OrdLsb) ? {in_bit, dstr_q[WIDTH-1:1]}
                                : {dstr_q[WIDTH-2:0], in_bit};
  end

  always_comb begin
    state_d  = state_q;
    dstr_d   = dstr_q;
    rx_d     = rx_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sample_d = sample_q;
    ord_d    = ord_q;

    if (ld_i) begin
      // Load wins over everything, aborting any frame without a done pulse.
      dstr_d  = ld_data_i;
      ord_d   = lsb_first_i;
      cnt_d   = '0;
      busy_d  = 1'b1;
      state_d = StShift;
    end else if (state_q == StShift) begin
      if (smp_i) begin
        sample_d = din_i;
      end
      if (sh_i) begin
        dstr_d = shifted;
        if (cnt_q == LastBit) begin
          rx_d    = shifted;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      dstr_q   <= '0;
      rx_q     <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sample_q <= 1'b0;
      ord_q    <= OrdMsb;
    end else begin
      state_q  <= state_d;
      dstr_q   <= dstr_d;
      rx_q     <= rx_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sample_q <= sample_d;
      ord_q    <= ord_d;
    end
  end

  assign dout_o    = busy_q ? ((ord_q == OrdLsb) ? dstr_q[0] : dstr_q[WIDTH-1]) : IDLE_OUT;
  assign dstr_o    = dstr_q;
  assign rx_data_o = rx_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign bit_cnt_o = cnt_q;

endmodule

// File: tb/tb_spi_shr.sv
// Self-checking bench for spi_shr: scoreboard of expected dout bits and
// received words for an 8-bit instance, plus a 16-bit loopback instance.
module tb_spi_shr;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // 8-bit instance
  logic       ld8 = 1'b0, lsb8 = 1'b0, smp8 = 1'b0, sh8 = 1'b0, din_drv8 = 1'b0;
  logic       loop8 = 1'b0;
  logic [7:0] ld_data8 = '0;
  logic       din8, dout8, busy8, done8;
  logic [7:0] dstr8, rx8;
  logic [2:0] cnt8;

  assign din8 = loop8 ? dout8 : din_drv8;

  spi_shr #(.WIDTH(8), .IDLE_OUT(1'b1)) u_dut8 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .ld_i       (ld8),
    .ld_data_i  (ld_data8),
    .lsb_first_i(lsb8),
    .smp_i      (smp8),
    .sh_i       (sh8),
    .din_i      (din8),
    .dout_o     (dout8),
    .dstr_o     (dstr8),
    .rx_data_o  (rx8),
    .busy_o     (busy8),
    .done_o     (done8),
    .bit_cnt_o  (cnt8)
  );

  // 16-bit instance, loopback only
  logic        ld16 = 1'b0, sh16 = 1'b0;
  logic [15:0] ld_data16 = '0;
  logic        dout16, busy16, done16;
  logic [15:0] dstr16, rx16;
  logic [3:0]  cnt16;

  spi_shr #(.WIDTH(16), .IDLE_OUT(1'b1)) u_dut16 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .ld_i       (ld16),
    .ld_data_i  (ld_data16),
    .lsb_first_i(1'b0),
    .smp_i      (sh16),
    .sh_i       (sh16),
    .din_i      (dout16),
    .dout_o     (dout16),
    .dstr_o     (dstr16),
    .rx_data_o  (rx16),
    .busy_o     (busy16),
    .done_o     (done16),
    .bit_cnt_o  (cnt16)
  );

  // Scoreboard: dout before each shift is always the original loaded bit.
  logic       exp_dout[$];
  logic [7:0] exp_rx[$];
  int         done_seen = 0;
  logic       done_prev = 1'b0;

  always @(negedge clk) begin
    if (sh8 && busy8 && !ld8) begin
      if (exp_dout.size() == 0) check("dout_underflow", 32'd1, 32'd0);
      else check("dout", 32'(dout8), 32'(exp_dout.pop_front()));
    end
    if (done8) begin
      done_seen++;
      if (done_prev) check("done_width", 32'd2, 32'd1);
      if (exp_rx.size() == 0) check("spurious_done", 32'(done8), 32'd0);
      else begin
        check("rx_data", 32'(rx8), 32'(exp_rx.pop_front()));
        check("busy_at_done", 32'(busy8), 32'd0);
      end
    end
    done_prev = done8;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load8(input logic [7:0] d, input logic lsb, input logic [7:0] rx_exp);
    exp_dout.delete();
    exp_rx.delete();
    for (int i = 0; i < 8; i++) exp_dout.push_back(lsb ? d[i] : d[7-i]);
    exp_rx.push_back(rx_exp);
    ld8 = 1'b1;
    ld_data8 = d;
    lsb8 = lsb;
    tick();
    ld8 = 1'b0;
  endtask

  // n back-to-back shifts with smp tied to sh
  task automatic shifts8(input int n);
    for (int i = 0; i < n; i++) begin
      sh8 = 1'b1;
      smp8 = 1'b1;
      tick();
    end
    sh8 = 1'b0;
    smp8 = 1'b0;
  endtask

  task automatic check_frame_end(input string tag, input logic [7:0] rx_exp);
    check({tag, "_done"}, 32'(done8), 32'd1);
    check({tag, "_busy"}, 32'(busy8), 32'd0);
    check({tag, "_rx"}, 32'(rx8), 32'(rx_exp));
    check({tag, "_idle_dout"}, 32'(dout8), 32'd1);
    check({tag, "_cnt"}, 32'(cnt8), 32'd0);
    tick();
    check({tag, "_done_drop"}, 32'(done8), 32'd0);
  endtask

  int         d0;
  logic [7:0] dstr_snap;
  logic [15:0] w16;

  initial begin
    // Reset values
    #12;
    check("rst_dout", 32'(dout8), 32'd1);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_dstr", 32'(dstr8), 32'd0);
    check("rst_rx", 32'(rx8), 32'd0);
    check("rst_cnt", 32'(cnt8), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();

    // Reset mid-frame is asynchronous and suppresses done
    loop8 = 1'b1;
    load8(8'hA5, 1'b0, 8'hA5);
    shifts8(3);
    check("mid_cnt", 32'(cnt8), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_dout", 32'(dout8), 32'd1);
    check("arst_busy", 32'(busy8), 32'd0);
    check("arst_dstr", 32'(dstr8), 32'd0);
    check("arst_cnt", 32'(cnt8), 32'd0);
    check("arst_rx", 32'(rx8), 32'd0);
    exp_dout.delete();
    exp_rx.delete();
    d0 = done_seen;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("arst_no_done", 32'(done_seen), 32'(d0));

    // MSB-first loopback
    load8(8'hA5, 1'b0, 8'hA5);
    check("msb_busy", 32'(busy8), 32'd1);
    shifts8(8);
    check_frame_end("msb", 8'hA5);

    // LSB-first, din held high, bit counter walk
    loop8 = 1'b0;
    din_drv8 = 1'b1;
    load8(8'h01, 1'b1, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      check("lsb_cnt", 32'(cnt8), 32'(i));
      sh8 = 1'b1;
      smp8 = 1'b1;
      tick();
    end
    sh8 = 1'b0;
    smp8 = 1'b0;
    check_frame_end("lsb", 8'hFF);

    // Split strobes: sample 1, shift with din 0, held sample must win
    load8(8'h00, 1'b0, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      smp8 = 1'b1;
      din_drv8 = 1'b1;
      tick();
      smp8 = 1'b0;
      sh8 = 1'b1;
      din_drv8 = 1'b0;
      tick();
      sh8 = 1'b0;
    end
    check_frame_end("cpha", 8'hFF);

    // Abort and restart
    loop8 = 1'b1;
    d0 = done_seen;
    load8(8'h3C, 1'b0, 8'h3C);
    shifts8(4);
    load8(8'h81, 1'b0, 8'h81);
    check("abort_cnt", 32'(cnt8), 32'd0);
    check("abort_busy", 32'(busy8), 32'd1);
    check("abort_dstr", 32'(dstr8), 32'h81);
    check("abort_no_done", 32'(done_seen), 32'(d0));
    shifts8(8);
    check_frame_end("restart", 8'h81);

    // Strobes in idle are ignored
    dstr_snap = dstr8;
    d0 = done_seen;
    for (int i = 0; i < 4; i++) begin
      sh8 = i[0];
      smp8 = 1'b1;
      tick();
    end
    sh8 = 1'b0;
    smp8 = 1'b0;
    tick();
    check("idle_dstr", 32'(dstr8), 32'(dstr_snap));
    check("idle_no_done", 32'(done_seen), 32'(d0));
    check("idle_dout", 32'(dout8), 32'd1);
    check("idle_busy", 32'(busy8), 32'd0);

    // 16-bit loopback
    w16 = 16'hBEEF;
    ld16 = 1'b1;
    ld_data16 = w16;
    tick();
    ld16 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("w16_dout", 32'(dout16), 32'(w16[15-i]));
      check("w16_cnt", 32'(cnt16), 32'(i));
      sh16 = 1'b1;
      tick();
    end
    sh16 = 1'b0;
    check("w16_done", 32'(done16), 32'd1);
    check("w16_rx", 32'(rx16), 32'hBEEF);
    check("w16_dout_idle", 32'(dout16), 32'd1);
    tick();
    check("w16_done_drop", 32'(done16), 32'd0);

    check("sb_rx_drained", 32'(exp_rx.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
